// File: rtl/skinny_sbox_sched_pkg.sv
// Shared types, constants and nibble helpers for the serial masked SKINNY-64
// S-box scheduler.
package skinny_sbox_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_RND,
    S_RUN,
    S_DONE
  } sched_state_t;

  localparam int NIB_W    = 4;
  localparam int STATE_W  = 64;
  localparam int SBOX_LAT = 11;
  localparam int RND_W    = 65;

  // Nibble slice of one share; idx 0 is bits [3:0].
  function automatic logic [3:0] nib_get(input logic [STATE_W-1:0] word,
                                         input logic [NIB_W-1:0]   idx);
    return word[{idx, 2'b00} +: 4];
  endfunction

  function automatic logic [STATE_W-1:0] nib_put(input logic [STATE_W-1:0] word,
                                                 input logic [NIB_W-1:0]   idx,
                                                 input logic [3:0]         val);
    logic [STATE_W-1:0] res;
    res = word;
    res[{idx, 2'b00} +: 4] = val;
    return res;
  endfunction

endpackage

// File: rtl/sched_share_buf.sv
// Per-share 64-bit work buffer with a nibble read mux and a nibble write port;
// every share lane is handled independently and never mixed with another.
module sched_share_buf
  import skinny_sbox_sched_pkg::*;
#(
  parameter int SHARES = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_i,
  input  logic [SHARES*STATE_W-1:0]   load_data_i,
  input  logic                        wr_en_i,
  input  logic [NIB_W-1:0]            nib_i,
  input  logic [SHARES*4-1:0]         wr_nib_i,
  output logic [SHARES*4-1:0]         rd_nib_o,
  output logic [SHARES*STATE_W-1:0]   merged_o
);

  logic [SHARES*STATE_W-1:0] workBuf_q;
  logic [SHARES*STATE_W-1:0] workBuf_d;
  logic [SHARES*STATE_W-1:0] wrMerged;

  // merged_o is the buffer as it will look after the pending nibble write,
  // so the final state can be published in the same edge as the last capture.
  always_comb begin
    rd_nib_o = '0;
    wrMerged = '0;
    for (int k = 0; k < SHARES; k++) begin
      rd_nib_o[4*k +: 4] = nib_get(workBuf_q[STATE_W*k +: STATE_W], nib_i);
      wrMerged[STATE_W*k +: STATE_W] =
        nib_put(workBuf_q[STATE_W*k +: STATE_W], nib_i, wr_nib_i[4*k +: 4]);
    end
  end

  always_comb begin
    workBuf_d = workBuf_q;
    if (load_i) begin
      workBuf_d = load_data_i;
    end else if (wr_en_i) begin
      workBuf_d = wrMerged;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      workBuf_q <= '0;
    end else begin
      workBuf_q <= workBuf_d;
    end
  end

  assign merged_o = wrMerged;

endmodule

// File: rtl/skinny_sbox_sched_d2.sv
// Serial scheduler feeding one shared, clock-gated 2nd-order HPC1 SKINNY-64
// S-box with every nibble of a 3-share state, one PRNG word per lookup.
module skinny_sbox_sched_d2
  import skinny_sbox_sched_pkg::*;
#(
  parameter int SHARES  = 3,
  parameter int NIBBLES = 16,
  parameter int RND_W   = 65,
  parameter int TIMEOUT = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  logic [SHARES*STATE_W-1:0]   state_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o,
  output logic [SHARES*STATE_W-1:0]   state_o,
  input  logic                        rnd_valid_i,
  input  logic [RND_W-1:0]            rnd_i,
  output logic                        rnd_ready_o,
  output logic [SHARES*4-1:0]         sb_si_o,
  output logic [RND_W-1:0]            sb_fresh_o,
  output logic                        sb_rst_o,
  input  logic                        sb_synch_i,
  input  logic [SHARES*4-1:0]         sb_so_i
);

  sched_state_t              state_q;
  logic [NIB_W-1:0]          nib_q;
  logic [3:0]                cnt_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      err_q;
  logic                      ready_q;
  logic                      sbRst_q;
  logic [RND_W-1:0]          fresh_q;
  logic [SHARES*STATE_W-1:0] stateOut_q;
  logic [SHARES*STATE_W-1:0] merged;
  logic                      captureEn;
  logic                      loadEn;

  // Synch during the reset cycle (cnt 0) belongs to the previous lookup.
  assign captureEn = (state_q == S_RUN) && sb_synch_i && (cnt_q != 4'd0);
  assign loadEn    = (state_q == S_IDLE) && start_i;

  sched_share_buf #(
    .SHARES (SHARES)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .load_i      (loadEn),
    .load_data_i (state_i),
    .wr_en_i     (captureEn),
    .nib_i       (nib_q),
    .wr_nib_i    (sb_so_i),
    .rd_nib_o    (sb_si_o),
    .merged_o    (merged)
  );

  // sbRst_q resets high so the S-box controller is held while rst is asserted;
  // afterwards it is only raised for the first RUN cycle of each lookup.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      nib_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
      sbRst_q    <= 1'b1;
      fresh_q    <= '0;
      stateOut_q <= '0;
    end else begin
      done_q  <= 1'b0;
      sbRst_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            nib_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            ready_q <= 1'b1;
            state_q <= S_WAIT_RND;
          end
        end
        S_WAIT_RND: begin
          if (rnd_valid_i) begin
            fresh_q <= rnd_i;
            cnt_q   <= '0;
            sbRst_q <= 1'b1;
            ready_q <= 1'b0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (cnt_q != 4'hF) begin
            cnt_q <= cnt_q + 4'd1;
          end
          if (captureEn) begin
            if (nib_q == NIB_W'(NIBBLES - 1)) begin
              stateOut_q <= merged;
              done_q     <= 1'b1;
              state_q    <= S_DONE;
            end else begin
              nib_q   <= nib_q + 4'd1;
              ready_q <= 1'b1;
              state_q <= S_WAIT_RND;
            end
          end else if (cnt_q == 4'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign state_o     = stateOut_q;
  assign rnd_ready_o = ready_q;
  assign sb_fresh_o  = fresh_q;
  assign sb_rst_o    = sbRst_q;

endmodule

// File: tb/tb_skinny_sbox_sched_d2.sv
// Directed bench for skinny_sbox_sched_d2 with a behavioural masked S-box
// that raises Synch a fixed number of cycles after its reset.
module tb_skinny_sbox_sched_d2;
  import skinny_sbox_sched_pkg::*;

  localparam logic [63:0] BASE    = 64'h0123456789ABCDEF;
  localparam logic [63:0] EXP_SUB = 64'hC6901A2B385D4E7F;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start_i = 1'b0;
  logic [191:0]       state_i = '0;
  logic               busy_o;
  logic               done_o;
  logic               err_o;
  logic [191:0]       state_o;
  logic               rnd_valid_i = 1'b0;
  logic [RND_W-1:0]   rnd_i = '0;
  logic               rnd_ready_o;
  logic [11:0]        sb_si_o;
  logic [RND_W-1:0]   sb_fresh_o;
  logic               sb_rst_o;
  logic               sb_synch_i;
  logic [11:0]        sb_so_i;

  int checks = 0;
  int errors = 0;
  int mcnt = 0;
  bit synchEn = 1'b1;

  skinny_sbox_sched_d2 #(
    .SHARES (3), .NIBBLES (16), .RND_W (RND_W), .TIMEOUT (15)
  ) dut (
    .clk (clk), .rst (rst), .start_i (start_i), .state_i (state_i),
    .busy_o (busy_o), .done_o (done_o), .err_o (err_o), .state_o (state_o),
    .rnd_valid_i (rnd_valid_i), .rnd_i (rnd_i), .rnd_ready_o (rnd_ready_o),
    .sb_si_o (sb_si_o), .sb_fresh_o (sb_fresh_o), .sb_rst_o (sb_rst_o),
    .sb_synch_i (sb_synch_i), .sb_so_i (sb_so_i)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC;  4'h1: return 4'h6;  4'h2: return 4'h9;  4'h3: return 4'h0;
      4'h4: return 4'h1;  4'h5: return 4'hA;  4'h6: return 4'h2;  4'h7: return 4'hB;
      4'h8: return 4'h3;  4'h9: return 4'h8;  4'hA: return 4'h5;  4'hB: return 4'hD;
      4'hC: return 4'h4;  4'hD: return 4'hE;  4'hE: return 4'h7;  default: return 4'hF;
    endcase
  endfunction

  function automatic logic [63:0] recomb(input logic [191:0] s);
    return s[63:0] ^ s[127:64] ^ s[191:128];
  endfunction

  // Masked S-box model: cycle count since its reset, output shares remasked
  // with two nibbles of the fresh word.
  always @(posedge clk) begin
    if (sb_rst_o) mcnt <= 1;
    else if (mcnt < 31) mcnt <= mcnt + 1;
  end

  always_comb begin
    logic [3:0] x;
    logic [3:0] m1;
    logic [3:0] m2;
    x  = sb_si_o[3:0] ^ sb_si_o[7:4] ^ sb_si_o[11:8];
    m1 = sb_fresh_o[3:0];
    m2 = sb_fresh_o[7:4];
    sb_so_i    = {m2, m1, sbox4(x) ^ m1 ^ m2};
    sb_synch_i = synchEn && (mcnt == SBOX_LAT);
  end

  task automatic run_pass(input logic [191:0] st, input int stallNib, input int stallLen,
                          input bit holdStart, input int nDone,
                          output int firstDone, output int lastDone, output logic [191:0] outSt,
                          output int hs, output bit freshOk, output bit siOk,
                          output logic [63:0] expSh1, output logic [63:0] expSh2);
    int n;
    int stallCnt;
    int doneCnt;
    int idx;
    logic [95:0] r;
    logic [RND_W-1:0] sent;
    logic [11:0] expSi;
    firstDone = -1; lastDone = -1; outSt = '0; hs = 0; freshOk = 1'b1; siOk = 1'b1;
    expSh1 = '0; expSh2 = '0; stallCnt = 0; doneCnt = 0; sent = '0; n = 0;
    @(negedge clk);
    state_i = st; start_i = 1'b1; rnd_valid_i = 1'b1;
    r = {$urandom, $urandom, $urandom}; rnd_i = r[RND_W-1:0];
    while (n < 1000 && doneCnt < nDone) begin
      @(negedge clk);
      n++;
      if (!holdStart) start_i = 1'b0;
      if (done_o) begin
        doneCnt++;
        if (doneCnt == 1) firstDone = n;
        lastDone = n;
        outSt = state_o;
      end
      if (busy_o && !rnd_ready_o && !done_o) begin
        idx = (hs + 15) % 16;
        expSi = {st[128 + 4*idx +: 4], st[64 + 4*idx +: 4], st[4*idx +: 4]};
        if (sb_fresh_o !== sent) freshOk = 1'b0;
        if (sb_si_o !== expSi) siOk = 1'b0;
      end
      r = {$urandom, $urandom, $urandom};
      if (rnd_ready_o) begin
        if ((hs % 16) == stallNib && stallCnt < stallLen) begin
          rnd_valid_i = 1'b0;
          stallCnt++;
        end else begin
          rnd_valid_i = 1'b1;
          rnd_i = r[RND_W-1:0];
          sent = r[RND_W-1:0];
          expSh1[4*(hs % 16) +: 4] = r[3:0];
          expSh2[4*(hs % 16) +: 4] = r[7:4];
          hs++;
        end
      end else begin
        rnd_valid_i = 1'b1;
        rnd_i = r[RND_W-1:0];
      end
    end
    start_i = 1'b0;
    rnd_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (sb_rst_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_sb_rst got %b expected 1", sb_rst_o); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({busy_o, done_o, err_o, rnd_ready_o} !== 4'b0) begin errors++; $display("[TB] FAIL reset_flags got %b expected 0000", {busy_o, done_o, err_o, rnd_ready_o}); end
    checks++; if (state_o !== '0) begin errors++; $display("[TB] FAIL reset_state_o got %h expected 0", state_o); end
    checks++; if (sb_si_o !== '0 || sb_fresh_o !== '0) begin errors++; $display("[TB] FAIL reset_sbox_ports got si=%h fresh=%h expected 0", sb_si_o, sb_fresh_o); end
  endtask

  task automatic test_basic();
    int fd, ld, hs;
    bit fok, sok;
    logic [191:0] o;
    logic [63:0] e1, e2;
    run_pass({64'h0, 64'h0, BASE}, -1, 0, 1'b0, 1, fd, ld, o, hs, fok, sok, e1, e2);
    checks++; if (fd !== 209) begin errors++; $display("[TB] FAIL basic_done_cycle got %0d expected 209", fd); end
    checks++; if (recomb(o) !== EXP_SUB) begin errors++; $display("[TB] FAIL basic_result got %h expected %h", recomb(o), EXP_SUB); end
    checks++; if (hs !== 16) begin errors++; $display("[TB] FAIL basic_handshakes got %0d expected 16", hs); end
    checks++; if (!fok) begin errors++; $display("[TB] FAIL basic_fresh_stable got 0 expected 1"); end
    checks++; if (!sok) begin errors++; $display("[TB] FAIL basic_si_nibble got 0 expected 1"); end
    checks++; if (o[127:64] !== e1 || o[191:128] !== e2) begin errors++; $display("[TB] FAIL basic_share_lanes got %h/%h expected %h/%h", o[127:64], o[191:128], e1, e2); end
    @(negedge clk);
    checks++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("[TB] FAIL basic_after_done got done=%b busy=%b expected 0/0", done_o, busy_o); end
  endtask

  task automatic test_timeout();
    int errAt;
    bit busyAtErr;
    bit doneSeen;
    int fd, ld, hs;
    bit fok, sok;
    logic [191:0] o;
    logic [63:0] e1, e2;
    synchEn = 1'b0; errAt = -1; busyAtErr = 1'b1; doneSeen = 1'b0;
    @(negedge clk);
    state_i = {64'h0, 64'h0, 64'hFFFF0000FFFF0000}; start_i = 1'b1; rnd_valid_i = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (done_o) doneSeen = 1'b1;
      if (err_o && errAt < 0) begin errAt = n; busyAtErr = busy_o; end
    end
    rnd_valid_i = 1'b0;
    checks++; if (errAt !== 17) begin errors++; $display("[TB] FAIL timeout_err_cycle got %0d expected 17", errAt); end
    checks++; if (busyAtErr !== 1'b0) begin errors++; $display("[TB] FAIL timeout_idle got busy=%b expected 0", busyAtErr); end
    checks++; if (doneSeen) begin errors++; $display("[TB] FAIL timeout_no_done got 1 expected 0"); end
    checks++; if (err_o !== 1'b1) begin errors++; $display("[TB] FAIL timeout_sticky got %b expected 1", err_o); end
    checks++; if (recomb(state_o) !== EXP_SUB) begin errors++; $display("[TB] FAIL timeout_state_kept got %h expected %h", recomb(state_o), EXP_SUB); end
    synchEn = 1'b1;
    run_pass({64'h0, 64'h0, BASE}, -1, 0, 1'b0, 1, fd, ld, o, hs, fok, sok, e1, e2);
    checks++; if (err_o !== 1'b0) begin errors++; $display("[TB] FAIL timeout_err_cleared got %b expected 0", err_o); end
    checks++; if (fd !== 209) begin errors++; $display("[TB] FAIL timeout_recover_done got %0d expected 209", fd); end
  endtask

  task automatic test_random_split();
    int fd, ld, hs;
    bit fok, sok;
    logic [191:0] o;
    logic [63:0] e1, e2, s1, s2;
    for (int i = 0; i < 100; i++) begin
      s1 = {$urandom, $urandom};
      s2 = {$urandom, $urandom};
      run_pass({s2, s1, BASE ^ s1 ^ s2}, -1, 0, 1'b0, 1, fd, ld, o, hs, fok, sok, e1, e2);
      checks++; if (recomb(o) !== EXP_SUB) begin errors++; $display("[TB] FAIL split_result pass %0d got %h expected %h", i, recomb(o), EXP_SUB); end
      checks++; if (hs !== 16) begin errors++; $display("[TB] FAIL split_handshakes pass %0d got %0d expected 16", i, hs); end
      checks++; if (fd !== 209 || !sok) begin errors++; $display("[TB] FAIL split_timing pass %0d got done=%0d si_ok=%b expected 209/1", i, fd, sok); end
    end
  endtask

  task automatic test_rnd_stall();
    int fd, ld, hs;
    bit fok, sok;
    logic [191:0] o;
    logic [63:0] e1, e2;
    run_pass({64'h0, 64'h0, BASE}, 3, 5, 1'b0, 1, fd, ld, o, hs, fok, sok, e1, e2);
    checks++; if (fd !== 214) begin errors++; $display("[TB] FAIL stall_done_cycle got %0d expected 214", fd); end
    checks++; if (!fok) begin errors++; $display("[TB] FAIL stall_fresh_stable got 0 expected 1"); end
    checks++; if (recomb(o) !== EXP_SUB) begin errors++; $display("[TB] FAIL stall_result got %h expected %h", recomb(o), EXP_SUB); end
  endtask

  task automatic test_reset_mid();
    bit doneSeen;
    bit busySeen;
    int fd, ld, hs;
    bit fok, sok;
    logic [191:0] o;
    logic [63:0] e1, e2;
    doneSeen = 1'b0; busySeen = 1'b0;
    @(negedge clk);
    state_i = {64'h0, 64'h0, BASE}; start_i = 1'b1; rnd_valid_i = 1'b1; rnd_i = '1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    rst = 1'b1;
    #1;
    checks++; if ({busy_o, done_o, err_o, rnd_ready_o} !== 4'b0) begin errors++; $display("[TB] FAIL midrst_flags got %b expected 0000", {busy_o, done_o, err_o, rnd_ready_o}); end
    checks++; if (state_o !== '0 || sb_si_o !== '0 || sb_fresh_o !== '0) begin errors++; $display("[TB] FAIL midrst_data got so=%h si=%h fr=%h expected 0", state_o, sb_si_o, sb_fresh_o); end
    checks++; if (sb_rst_o !== 1'b1) begin errors++; $display("[TB] FAIL midrst_sb_rst got %b expected 1", sb_rst_o); end
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done_o) doneSeen = 1'b1;
      if (busy_o) busySeen = 1'b1;
    end
    rnd_valid_i = 1'b0;
    checks++; if (doneSeen || busySeen) begin errors++; $display("[TB] FAIL midrst_quiet got done=%b busy=%b expected 0/0", doneSeen, busySeen); end
    run_pass({64'h0, 64'h0, BASE}, -1, 0, 1'b0, 1, fd, ld, o, hs, fok, sok, e1, e2);
    checks++; if (fd !== 209 || recomb(o) !== EXP_SUB) begin errors++; $display("[TB] FAIL midrst_next_pass got done=%0d res=%h expected 209/%h", fd, recomb(o), EXP_SUB); end
  endtask

  task automatic test_back_to_back();
    int fd, ld, hs;
    bit fok, sok;
    logic [191:0] o;
    logic [63:0] e1, e2;
    run_pass({64'h0, 64'h0, BASE}, -1, 0, 1'b1, 2, fd, ld, o, hs, fok, sok, e1, e2);
    checks++; if (fd !== 209) begin errors++; $display("[TB] FAIL b2b_first_done got %0d expected 209", fd); end
    checks++; if (ld !== 419) begin errors++; $display("[TB] FAIL b2b_second_done got %0d expected 419", ld); end
    checks++; if (hs !== 32) begin errors++; $display("[TB] FAIL b2b_handshakes got %0d expected 32", hs); end
    checks++; if (recomb(o) !== EXP_SUB) begin errors++; $display("[TB] FAIL b2b_result got %h expected %h", recomb(o), EXP_SUB); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_random_split();
    test_rnd_stall();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
